// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU (A)
// and load (B) writeback paths, with an optional post-reset zero sweep of R1..R31.
module regfile_write_arbiter #(
  parameter bit INIT_EN = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        reqA_valid,
  input  logic [4:0]  reqA_rd,
  input  logic [31:0] reqA_data,
  output logic        reqA_ready,
  input  logic        reqB_valid,
  input  logic [4:0]  reqB_rd,
  input  logic [31:0] reqB_data,
  output logic        reqB_ready,
  output logic [4:0]  RD,
  output logic [31:0] dataRD,
  output logic        RW,
  output logic        busy
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RESET = INIT_EN ? ST_INIT : ST_RUN;

  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  localparam logic [4:0] LAST_REG = 5'd31;

  logic [0:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;

  logic        run;
  logic        grant_a;
  logic        grant_b;

  // Readies are gated by Reset so no grant is offered while reset is held,
  // even when INIT_EN=0 parks the state in RUN.
  assign run     = (state_q == ST_RUN) && !Reset;
  assign grant_a = run && reqA_valid && (!reqB_valid || (ptr_q == PTR_A));
  assign grant_b = run && reqB_valid && (!reqA_valid || (ptr_q == PTR_B));

  assign reqA_ready = grant_a;
  assign reqB_ready = grant_b;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    rd_d    = rd_q;
    data_d  = data_q;
    rw_d    = 1'b0;
    busy_d  = busy_q;

    if (state_q == ST_INIT) begin
      rw_d   = 1'b1;
      rd_d   = cnt_q;
      data_d = '0;
      cnt_d  = cnt_q + 5'd1;
      if (cnt_q == LAST_REG) begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
      end
    end else if (grant_a) begin
      rd_d   = reqA_rd;
      data_d = reqA_data;
      rw_d   = (reqA_rd != 5'd0);
      ptr_d  = PTR_B;
    end else if (grant_b) begin
      rd_d   = reqB_rd;
      data_d = reqB_data;
      rw_d   = (reqB_rd != 5'd0);
      ptr_d  = PTR_A;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_RESET;
      cnt_q   <= 5'd1;
      ptr_q   <= PTR_A;
      rd_q    <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      busy_q  <= INIT_EN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
    end
  end

  assign RD     = rd_q;
  assign dataRD = data_q;
  assign RW     = rw_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios on an INIT_EN=1 and an
// INIT_EN=0 instance, plus randomized traffic against a round-robin model.
module tb_regfile_write_arbiter;

  logic        clk;
  int          tests;
  int          fails;

  // INIT_EN=1 instance
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, rd;
  logic [31:0] a_data, b_data, data;
  logic        rw, busy;

  // INIT_EN=0 instance
  logic        rst_z;
  logic        a_valid_z, b_valid_z, a_ready_z, b_ready_z;
  logic [4:0]  a_rd_z, b_rd_z, rd_z;
  logic [31:0] a_data_z, b_data_z, data_z;
  logic        rw_z, busy_z;

  regfile_write_arbiter #(.INIT_EN(1'b1)) dut (
    .Clk(clk), .Reset(rst),
    .reqA_valid(a_valid), .reqA_rd(a_rd), .reqA_data(a_data), .reqA_ready(a_ready),
    .reqB_valid(b_valid), .reqB_rd(b_rd), .reqB_data(b_data), .reqB_ready(b_ready),
    .RD(rd), .dataRD(data), .RW(rw), .busy(busy)
  );

  regfile_write_arbiter #(.INIT_EN(1'b0)) dut_z (
    .Clk(clk), .Reset(rst_z),
    .reqA_valid(a_valid_z), .reqA_rd(a_rd_z), .reqA_data(a_data_z), .reqA_ready(a_ready_z),
    .reqB_valid(b_valid_z), .reqB_rd(b_rd_z), .reqB_data(b_data_z), .reqB_ready(b_ready_z),
    .RD(rd_z), .dataRD(data_z), .RW(rw_z), .busy(busy_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; rst_z = 1'b1;
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h11111111;
    b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h22222222;
    a_valid_z = 1'b1; a_rd_z = 5'd3; a_data_z = 32'd42;
    b_valid_z = 1'b0; b_rd_z = 5'd0; b_data_z = 32'd0;
    #1;
    tests++;
    if ({rw, rd, data, busy, a_ready, b_ready} !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_init_en1: rw=%b rd=%0d data=%h busy=%b rdyA=%b rdyB=%b, want 0 0 0 1 0 0",
               rw, rd, data, busy, a_ready, b_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({rw_z, rd_z, data_z, busy_z, a_ready_z, b_ready_z} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_init_en0: rw=%b rd=%0d data=%h busy=%b rdyA=%b rdyB=%b, want 0 0 0 0 0 0",
               rw_z, rd_z, data_z, busy_z, a_ready_z, b_ready_z);
    end
  endtask

  // Runs a full sweep from a released reset; both valids stay high throughout.
  task automatic run_sweep(input string tag);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      #1;
      tests++;
      if ({a_ready, b_ready} !== 2'b00) begin
        fails++;
        $display("FAIL %s_ready_cycle%0d: rdyA=%b rdyB=%b, want 0 0", tag, k, a_ready, b_ready);
      end
      @(posedge clk); #1;
      tests++;
      if ({rw, rd, data, busy} !== {1'b1, 5'(k), 32'd0, (k < 31)}) begin
        fails++;
        $display("FAIL %s_edge%0d: rw=%b rd=%0d data=%h busy=%b, want 1 %0d 0 %b",
                 tag, k, rw, rd, data, busy, k, (k < 31));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_init_sweep();
    run_sweep("sweep");
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++;
      if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL contention_grant%0d: rdyA=%b rdyB=%b, want %s", i, a_ready, b_ready,
                 (i % 2 == 0) ? "A" : "B");
      end
      @(posedge clk); #1;
      tests++;
      if ({rw, rd, data} !== ((i % 2 == 0) ? {1'b1, 5'd5, 32'h11111111} : {1'b1, 5'd6, 32'h22222222})) begin
        fails++;
        $display("FAIL contention_write%0d: rw=%b rd=%0d data=%h", i, rw, rd, data);
      end
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_r0_drop();
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hDEADBEEF; b_valid = 1'b0;
    #1;
    tests++;
    if ({a_ready, b_ready} !== 2'b10) begin
      fails++;
      $display("FAIL r0_ready: rdyA=%b rdyB=%b, want 1 0", a_ready, b_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (rw !== 1'b0) begin
      fails++;
      $display("FAIL r0_dropped: rw=%b, want 0", rw);
    end
    @(negedge clk);
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hAAAA0001;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'hBBBB0002;
    #1;
    tests++;
    if ({a_ready, b_ready} !== 2'b01) begin
      fails++;
      $display("FAIL r0_ptr_flip: rdyA=%b rdyB=%b, want 0 1", a_ready, b_ready);
    end
    @(posedge clk); #1;
    tests++;
    if ({rw, rd, data} !== {1'b1, 5'd2, 32'hBBBB0002}) begin
      fails++;
      $display("FAIL r0_followup_write: rw=%b rd=%0d data=%h, want 1 2 bbbb0002", rw, rd, data);
    end
  endtask

  task automatic test_idle_hold();
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b1; b_rd = 5'd9; b_data = 32'd7;
    #1;
    tests++;
    if ({a_ready, b_ready} !== 2'b01) begin
      fails++;
      $display("FAIL idle_grant: rdyA=%b rdyB=%b, want 0 1", a_ready, b_ready);
    end
    @(posedge clk); #1;
    tests++;
    if ({rw, rd, data} !== {1'b1, 5'd9, 32'd7}) begin
      fails++;
      $display("FAIL idle_write: rw=%b rd=%0d data=%h, want 1 9 7", rw, rd, data);
    end
    @(negedge clk);
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if ({a_ready, b_ready} !== 2'b00) begin
        fails++;
        $display("FAIL idle_ready%0d: rdyA=%b rdyB=%b, want 0 0", i, a_ready, b_ready);
      end
      @(posedge clk); #1;
      tests++;
      if ({rw, rd, data} !== {1'b0, 5'd9, 32'd7}) begin
        fails++;
        $display("FAIL idle_hold%0d: rw=%b rd=%0d data=%h, want 0 9 7", i, rw, rd, data);
      end
      @(negedge clk);
    end
  endtask

  // Model: each requester holds a pending write until granted; on contention
  // the requester that did not win the most recent grant goes first.
  task automatic test_random();
    logic        pa, pb, ga, gb, last_was_a;
    logic [4:0]  ra, rb, exp_rd;
    logic [31:0] da, db, exp_data;
    logic        exp_rw;
    pa = 1'b0; pb = 1'b0; ra = '0; rb = '0; da = '0; db = '0;
    last_was_a = 1'b0;  // B won last (idle test), so A has priority
    exp_rd = 5'd9; exp_data = 32'd7;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; ra = 5'($urandom_range(0, 31)); da = $urandom;
      end
      if (!pb && $urandom_range(0, 2) != 0) begin
        pb = 1'b1; rb = 5'($urandom_range(0, 31)); db = $urandom;
      end
      a_valid = pa; a_rd = ra; a_data = da;
      b_valid = pb; b_rd = rb; b_data = db;
      #1;
      ga = pa && (!pb || last_was_a == 1'b0);
      gb = pb && !ga;
      tests++;
      if ({a_ready, b_ready} !== {ga, gb}) begin
        fails++;
        $display("FAIL random_grant%0d: rdyA=%b rdyB=%b, want %b %b", i, a_ready, b_ready, ga, gb);
      end
      exp_rw = 1'b0;
      if (ga) begin
        exp_rd = ra; exp_data = da; exp_rw = (ra != 5'd0); last_was_a = 1'b1; pa = 1'b0;
      end else if (gb) begin
        exp_rd = rb; exp_data = db; exp_rw = (rb != 5'd0); last_was_a = 1'b0; pb = 1'b0;
      end
      @(posedge clk); #1;
      tests++;
      if ({rw, rd, data} !== {exp_rw, exp_rd, exp_data}) begin
        fails++;
        $display("FAIL random_write%0d: rw=%b rd=%0d data=%h, want %b %0d %h",
                 i, rw, rd, data, exp_rw, exp_rd, exp_data);
      end
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if ({rw, rd, busy} !== {1'b1, 5'd10, 1'b1}) begin
      fails++;
      $display("FAIL midsweep_edge10: rw=%b rd=%0d busy=%b, want 1 10 1", rw, rd, busy);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({rw, rd, data, busy, a_ready, b_ready} !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midsweep_reset: rw=%b rd=%0d data=%h busy=%b rdyA=%b rdyB=%b, want 0 0 0 1 0 0",
               rw, rd, data, busy, a_ready, b_ready);
    end
    run_sweep("resweep");
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_init_en0();
    @(negedge clk);
    rst_z = 1'b0;
    a_valid_z = 1'b1; a_rd_z = 5'd3; a_data_z = 32'd42;
    #1;
    tests++;
    if ({a_ready_z, b_ready_z, busy_z} !== 3'b100) begin
      fails++;
      $display("FAIL en0_ready: rdyA=%b rdyB=%b busy=%b, want 1 0 0", a_ready_z, b_ready_z, busy_z);
    end
    @(posedge clk); #1;
    tests++;
    if ({rw_z, rd_z, data_z, busy_z} !== {1'b1, 5'd3, 32'd42, 1'b0}) begin
      fails++;
      $display("FAIL en0_write: rw=%b rd=%0d data=%h busy=%b, want 1 3 2a 0", rw_z, rd_z, data_z, busy_z);
    end
    @(negedge clk);
    a_valid_z = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({rw_z, rd_z, data_z, busy_z} !== {1'b0, 5'd3, 32'd42, 1'b0}) begin
      fails++;
      $display("FAIL en0_idle: rw=%b rd=%0d data=%h busy=%b, want 0 3 2a 0", rw_z, rd_z, data_z, busy_z);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_init_sweep();
    test_contention();
    test_r0_drop();
    test_idle_hold();
    test_random();
    test_reset_mid_sweep();
    test_init_en0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
